mmio_anim_master: RTL

Hardware bus initiator for the processor's MMIO memory port. It periodically reads the button register, advances the animation frame index, and writes the frame and LED registers through the same `wEn`/`addr`/data interface the CPU uses. The CPU does not need to poll. It sits between the display timebase and the MMIO RAM, with access arbitrated by a req/gnt handshake.

---
 rtl/mmio_anim_master.sv | 87 ++++++++
 1 files changed

// File: rtl/mmio_anim_master.sv
// mmio_anim_master: tick-driven MMIO initiator reading BTNU and writing frame (plus LED mirror when ANIM_LED_MIRROR_EN is defined)
module mmio_anim_master #(
  parameter logic [31:0] TICK_CYCLES = 32'd1000000,
  parameter int unsigned NUM_FRAMES = 64,
  parameter logic [11:0] ADDR_BTN = 12'd1000,
  parameter logic [11:0] ADDR_LED = 12'd1001,
  parameter logic [11:0] ADDR_FRAME = 12'd1002
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        wEn,
  output logic [11:0] addr,
  output logic [31:0] dataOut,
  input  logic [31:0] dataIn,
  output logic [7:0]  frame,
  output logic        paused,
  output logic        overrun
);
  typedef enum logic [2:0] {IDLE, REQ, RD_BTN, WR_FRAME, WR_LED} state_t;
  localparam logic [7:0] LAST = 8'(NUM_FRAMES - 1);
  state_t state, state_n;
  logic [31:0] cnt;
  logic pending, tick;
  logic [7:0] nxt_frame;
  logic unused_data;
  assign unused_data = ^dataIn[31:1];
  assign tick = enable && cnt == TICK_CYCLES - 32'd1;
  assign nxt_frame = paused ? frame : (frame == LAST ? 8'd0 : frame + 8'd1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
      frame <= '0;
      paused <= 1'b0;
    end else begin
      state <= state_n;
      if (enable) cnt <= tick ? '0 : cnt + 32'd1;
      pending <= (state == IDLE) ? 1'b0 : (pending | tick);
      overrun <= overrun | (tick & pending);
      if (state == RD_BTN && bus_gnt) paused <= dataIn[0];
      if (state == WR_FRAME && bus_gnt) frame <= nxt_frame;
    end
  end
  always_comb begin
    state_n = state;
    bus_req = 1'b0;
    wEn = 1'b0;
    addr = '0;
    dataOut = '0;
    case (state)
      IDLE: state_n = (tick || pending) ? REQ : IDLE;
      REQ: begin
        bus_req = 1'b1;
        state_n = bus_gnt ? RD_BTN : REQ;
      end
      RD_BTN: begin
        bus_req = 1'b1;
        addr = ADDR_BTN;
        state_n = bus_gnt ? WR_FRAME : RD_BTN;
      end
      WR_FRAME: begin
        bus_req = 1'b1;
        addr = ADDR_FRAME;
        wEn = bus_gnt;
        dataOut = {24'd0, nxt_frame};
`ifdef ANIM_LED_MIRROR_EN
        state_n = bus_gnt ? WR_LED : WR_FRAME;
`else
        state_n = bus_gnt ? IDLE : WR_FRAME;
`endif
      end
      WR_LED: begin
        bus_req = 1'b1;
        addr = ADDR_LED;
        wEn = bus_gnt;
        dataOut = {27'd0, frame[4:0]};
        state_n = bus_gnt ? IDLE : WR_LED;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
